// File: rtl/pwl_tanh_pipe.sv
// Pipelined piecewise-linear tanh for the p-bit datapath.
// Stage 1 scales the input by 2^beta_shift and clamps it to [-4, 4).
// Stage 2 selects a linear segment and produces a signed Q1.(OUT_BITS-1) result.
// Both stages use valid/ready flow control; throughput is one sample per cycle.
module pwl_tanh_pipe #(
  parameter int unsigned IN_W     = 6,
  parameter int unsigned IN_FRAC  = 2,
  parameter int unsigned OUT_BITS = 8,
  parameter int unsigned BETA_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_data,
  input  logic [BETA_W-1:0]   beta_shift,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
);

  // Clamped x carries 3 integer bits (sign + range [-4, 4)).
  localparam int unsigned CW  = IN_FRAC + 3;
  localparam int unsigned SW  = IN_W + 2**BETA_W - 1;
  localparam int unsigned XW  = (SW > CW) ? SW : CW + 1;
  // Two guard bits hold |x| up to 4 once aligned to OUT_BITS-1 fractional bits.
  localparam int unsigned W2  = OUT_BITS + 2;
  localparam int unsigned ASH = OUT_BITS - 1 - IN_FRAC;

  if (OUT_BITS < IN_FRAC + 3) begin : g_bad_cfg
    $fatal(1, "pwl_tanh_pipe: OUT_BITS must be >= IN_FRAC+3");
  end

  localparam logic signed [XW-1:0] CMAX   = XW'(2**(CW-1) - 1);
  localparam logic signed [XW-1:0] CMIN   = ~CMAX;
  localparam logic [CW-1:0]        CMAX_C = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0]        CMIN_C = {1'b1, {(CW-1){1'b0}}};

  localparam logic signed [W2-1:0] QTR  = W2'(2**(OUT_BITS-3));
  localparam logic signed [W2-1:0] HALF = W2'(2**(OUT_BITS-2));
  localparam logic signed [W2-1:0] ONE  = W2'(2**(OUT_BITS-1));
  localparam logic signed [W2-1:0] TWO  = W2'(2**OUT_BITS);
  localparam logic signed [W2-1:0] NHALF = -HALF;
  localparam logic signed [W2-1:0] NONE  = -ONE;
  localparam logic signed [W2-1:0] NTWO  = -TWO;

  // Symmetric saturation: the most negative code is never produced.
  localparam logic [OUT_BITS-1:0] SAT_P = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic [OUT_BITS-1:0] SAT_N = {1'b1, {(OUT_BITS-2){1'b0}}, 1'b1};

  logic                    s1_valid;
  logic [CW-1:0]           s1_x;
  logic [CW-1:0]           s1_x_d;
  logic                    s1_advance;
  logic signed [XW-1:0]    xw;
  logic signed [XW-1:0]    xs;
  logic signed [W2-1:0]    xa;
  logic [OUT_BITS-1:0]     out_d;

  // Output stage can take a new value when empty or when its value is leaving.
  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  // Stage 1 combinational: widen, scale by beta, clamp to the representable range.
  always_comb begin
    xw     = $signed({{(XW-IN_W){in_data[IN_W-1]}}, in_data});
    xs     = xw <<< beta_shift;
    s1_x_d = xs[CW-1:0];
    if (xs > CMAX) begin
      s1_x_d = CMAX_C;
    end else if (xs < CMIN) begin
      s1_x_d = CMIN_C;
    end
  end

  // Stage 2 combinational: align x to the output fraction, then pick a segment.
  always_comb begin
    xa    = $signed({{(W2-CW){s1_x[CW-1]}}, s1_x}) <<< ASH;
    out_d = xa[OUT_BITS-1:0];
    if (xa >= TWO) begin
      out_d = SAT_P;
    end else if (xa <= NTWO) begin
      out_d = SAT_N;
    end else if (xa >= ONE) begin
      out_d = OUT_BITS'((xa >>> 2) + HALF);
    end else if (xa <= NONE) begin
      out_d = OUT_BITS'((xa >>> 2) - HALF);
    end else if (xa >= HALF) begin
      out_d = OUT_BITS'((xa >>> 1) + QTR);
    end else if (xa <= NHALF) begin
      out_d = OUT_BITS'((xa >>> 1) - QTR);
    end
  end

  // Stage 1 register: capture the clamped sample whenever the stage can accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x <= s1_x_d;
      end
    end
  end

  // Output register: hold while stalled, otherwise take stage 1's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= out_d;
      end
    end
  end

endmodule

// File: tb/tb_pwl_tanh_pipe.sv
// Self-checking bench for pwl_tanh_pipe: real-valued reference model, scoreboard
// queue, directed segment/beta/back-pressure/reset tests and a random phase.
module tb_pwl_tanh_pipe;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [5:0] in_data = '0;
  logic [1:0]        beta_shift = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_data;

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];
  int cyc = 0;
  int out_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit saw_stall = 1'b0;
  bit hold_pending = 1'b0;
  int held = 0;

  pwl_tanh_pipe #(
    .IN_W(6),
    .IN_FRAC(2),
    .OUT_BITS(8),
    .BETA_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .beta_shift(beta_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Reference: tanh approximation evaluated on real numbers, returned in 1/128 units.
  function automatic int ref_tanh(input int d, input int b);
    int  x;
    real xr;
    real r;
    x = d * (1 << b);
    if (x > 15) x = 15;
    if (x < -16) x = -16;
    xr = x / 4.0;
    if (xr >= 2.0) return 127;
    if (xr <= -2.0) return -127;
    if (xr >= 1.0) r = xr / 4.0 + 0.5;
    else if (xr <= -1.0) r = xr / 4.0 - 0.5;
    else if (xr >= 0.5) r = xr / 2.0 + 0.25;
    else if (xr <= -0.5) r = xr / 2.0 - 0.25;
    else r = xr;
    return $rtoi(r * 128.0);
  endfunction

  function automatic int sdata(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Compare process: at each negedge, score the transfers due on the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", sdata(out_data), held);
      end
      hold_pending = 1'b0;
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("expected_queue_depth", exp_q.size(), 1);
        end else begin
          chk("out_data", sdata(out_data), exp_q.pop_front());
          out_cnt++;
          if (out_cnt == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
      end else if (out_valid) begin
        hold_pending = 1'b1;
        held = sdata(out_data);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_tanh(int'(in_data), int'(beta_shift)));
    end
  end

  // One isolated sample: checks the literal result and the 2-cycle latency.
  task automatic send_one(input int d, input int b, input int lit);
    int lat;
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 6'(d);
    beta_shift = 2'(b);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("one_accept", int'(ok), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("latency", lat, 2);
    chk("literal_out", sdata(out_data), lit);
  endtask

  // Back-to-back samples start, start+1, ... honouring in_ready.
  task automatic send_seq(input int start, input int n);
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = 6'(start + i);
      beta_shift = '0;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
      end
      chk("seq_accept", int'(ok), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    in_valid = 1'b0;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  int sw_in[12]  = '{1, 2, 4, 7, 8, 31, -1, -2, -4, -8, -32, 0};
  int sw_out[12] = '{32, 64, 96, 120, 127, 127, -32, -64, -96, -127, -127, 0};
  int bt_in[4]   = '{2, 1, 1, -31};
  int bt_sh[4]   = '{1, 2, 3, 3};
  int bt_out[4]  = '{96, 96, 127, -127};

  initial begin
    // Reset with a pending input.
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 6'sd5;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", sdata(out_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    // Segment sweep and beta scaling, each pinned by hand-computed values.
    for (int i = 0; i < 12; i++) begin
      chk("model_sweep", ref_tanh(sw_in[i], 0), sw_out[i]);
      send_one(sw_in[i], 0, sw_out[i]);
    end
    for (int i = 0; i < 4; i++) begin
      chk("model_beta", ref_tanh(bt_in[i], bt_sh[i]), bt_out[i]);
      send_one(bt_in[i], bt_sh[i], bt_out[i]);
    end
    drain("sweep_drain");

    // Back-pressure: 5 samples, out_ready low for 3 cycles after the first output.
    @(posedge clk); #1;
    out_cnt = 0;
    saw_stall = 1'b0;
    fork
      send_seq(-3, 5);
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", out_cnt, 5);
    chk("bp_in_ready_fell", int'(saw_stall), 1);

    // Full throughput: 64 back-to-back samples.
    @(posedge clk); #1;
    out_cnt = 0;
    send_seq(-32, 64);
    drain("tp_drain");
    chk("tp_count", out_cnt, 64);
    chk("tp_consecutive", last_cyc - first_cyc, 63);

    // Random traffic on both sides, including beta changes during stalls.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 6'($urandom);
      beta_shift = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    drain("rand_drain");

    // Mid-stream reset with two samples in flight.
    send_seq(5, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", sdata(out_data), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_one(4, 0, 96);
    @(posedge clk); #1;
    drain("midrst_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwl_tanh_pipe.md
Name: pwl_tanh_pipe

Overview:
Pipelined, parametrised piecewise-linear tanh for the p-bit datapath. It is the successor to the combinational approximator and adds:
- configurable input and output widths;
- per-sample inverse-temperature (beta) scaling by a power of two;
- a 2-stage registered pipeline with valid/ready flow control on both sides.
It sits between the p-bit weighted-sum accumulator and the random-number comparator.

Parameters:
IN_W, 6, input width; signed two's complement.
IN_FRAC, 2, number of fractional bits in in_data.
OUT_BITS, 8, output width; signed fixed point with OUT_BITS-1 fractional bits (range -1 to 1-2^-(OUT_BITS-1)).
BETA_W, 2, width of beta_shift; shift range is 0..2^BETA_W-1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_data  in  IN_W  input x, signed, IN_FRAC fractional bits
beta_shift  in  BETA_W  left-shift amount applied to x; sampled with in_data
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_data  out  OUT_BITS  tanh approximation

Behaviour:
- Reset (async assert, sync release): s1_valid=0, out_valid=0, out_data=0, all stage registers 0. in_ready=1 one cycle after reset release.
- Handshake: a transfer occurs on a rising edge where valid&&ready.
  - Input side: in_ready = !s1_valid || s1_advance, where s1_advance = !out_valid || out_ready.
  - Output side: out_valid/out_data are held stable while out_valid && !out_ready.
  - Simultaneous output consume and input accept in the same cycle are both honoured.
  - Throughput is 1 sample/cycle when out_ready is held high.
- Latency: exactly 2 cycles from input transfer to out_valid, when not stalled.
- Stage 1 (scale + clamp):
  - xs = in_data <<< beta_shift, computed at IN_W+2^BETA_W-1 bits (no overflow).
  - Clamp xs to [-4, 4-2^-IN_FRAC] and register it (IN_FRAC+3 bits) together with valid.
- Stage 2 (segment select + evaluate), with x = clamped xs:
  - R0: -0.5 < x < 0.5 → out = x.
  - R1: 0.5 ≤ x < 1 → out = x/2 + 0.25. For -1 < x ≤ -0.5 → out = x/2 - 0.25.
  - R2: 1 ≤ x < 2 → out = x/4 + 0.5. For -2 < x ≤ -1 → out = x/4 - 0.5.
  - SAT: x ≥ 2 → +(1-2^-(OUT_BITS-1)). x ≤ -2 → -(1-2^-(OUT_BITS-1)). Saturation is symmetric; code -2^(OUT_BITS-1) is never produced.
- Arithmetic rules:
  - Align x to OUT_BITS-1 fractional bits before shifting.
  - Divisions are arithmetic right shifts. Exact given the constraint below.
  - Offsets are added in OUT_BITS+2-bit signed arithmetic, then truncated to OUT_BITS. Results are in range by construction.
- Constraint: OUT_BITS ≥ IN_FRAC+3, checked at elaboration; fatal if violated.
- beta_shift is used only in the cycle its sample is accepted. Changing it while stalled has no effect on in-flight data.
- Reset mid-operation: in-flight samples are discarded and out_valid drops immediately on rst_n low.

Test Plan:
- Reset: rst_n=0 with in_valid=1 → out_valid=0, out_data=0. After release, in_ready=1.
- Segment sweep (defaults, beta=0, out_ready=1): in_data → out_data, each appearing 2 cycles after acceptance:
  - 1 → 32
  - 2 → 64
  - 4 → 96
  - 7 → 120
  - 8 → 127
  - 31 → 127
  - -1 → -32
  - -2 → -64
  - -4 → -96
  - -8 → -127
  - -32 → -127
  - 0 → 0
- Beta scaling:
  - in=2, beta=1 → 96.
  - in=1, beta=2 → 96.
  - in=1, beta=3 → 127.
  - in=-31, beta=3 → -127 (wide-shift clamp).
- Back-pressure:
  - Stream 5 samples. Drop out_ready for 3 cycles after the first out_valid.
  - Required: out_data stays constant, in_ready falls once both stages are full, no sample is lost or duplicated, order is preserved.
- Full throughput: 64 back-to-back samples (-32..31) with out_ready=1 → 64 outputs on consecutive cycles, matching the reference model.
- Mid-stream reset: assert rst_n=0 while 2 samples are in flight → out_valid=0 immediately. After release, the first new sample is output with 2-cycle latency.
